// File: rtl/pb_pkg.sv
// Shared helpers for the pushbutton conditioner: idle level, counter widths
// and the default timing constants.
package pb_pkg;

    localparam int DEF_DB_CYCLES   = 16;
    localparam int DEF_LONG_CYCLES = 1000;

    // Widths for the default configuration; instances with other timing
    // derive their own widths through cnt_w().
    localparam int DB_W   = $clog2(DEF_DB_CYCLES + 1);
    localparam int LONG_W = $clog2(DEF_LONG_CYCLES + 1);

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Level seen on an unpressed button.
    function automatic logic idle_lvl(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/pb_debounce_ch.sv
// One button channel: two-flop synchroniser, stable-count debounce, press /
// release edge pulses and long-press detection.
module pb_debounce_ch
    import pb_pkg::*;
#(
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int LONG_CYCLES = DEF_LONG_CYCLES,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb,
    input  logic tick,
    output logic held,
    output logic pressed,
    output logic released,
    output logic long_press,
    output logic long_held
);

    localparam int DBW = cnt_w(DB_CYCLES);
    localparam int LW  = cnt_w(LONG_CYCLES);

    localparam logic            IDLE      = idle_lvl(ACTIVE_LOW);
    localparam logic            POLARITY  = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [DBW-1:0]  DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [DBW-1:0]  DB_ONE    = DBW'(1);
    localparam logic [LW-1:0]   LONG_MAX  = LW'(LONG_CYCLES);
    localparam logic [LW-1:0]   LONG_PRE  = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0]   LONG_ONE  = LW'(1);

    logic           sync1_q,    sync1_d;
    logic           sync2_q,    sync2_d;
    logic           held_q,     held_d;
    logic           held_dly_q, held_dly_d;
    logic [DBW-1:0] db_cnt_q,   db_cnt_d;
    logic [LW-1:0]  hold_cnt_q, hold_cnt_d;
    logic           long_held_q, long_held_d;

    logic act;

    assign act = sync2_q ^ POLARITY;

    always_comb begin
        sync1_d    = pb;
        sync2_d    = sync1_q;
        held_dly_d = held_q;
        held_d     = held_q;
        db_cnt_d   = db_cnt_q;

        // Any sample that agrees with the accepted level restarts the run.
        if (act == held_q) begin
            db_cnt_d = '0;
        end else if (tick) begin
            if (db_cnt_q == DB_LAST) begin
                held_d   = act;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_ONE;
            end
        end
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (!held_q) begin
            hold_cnt_d = '0;
        end else if (tick && (hold_cnt_q != LONG_MAX)) begin
            hold_cnt_d = hold_cnt_q + LONG_ONE;
        end
        // Gated by the next held level so long_held falls with the release pulse.
        long_held_d = held_d && (hold_cnt_d == LONG_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= IDLE;
            sync2_q     <= IDLE;
            held_q      <= 1'b0;
            held_dly_q  <= 1'b0;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            long_held_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            held_q      <= held_d;
            held_dly_q  <= held_dly_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_held_q <= long_held_d;
        end
    end

    assign held       = held_q;
    assign pressed    = held_q & ~held_dly_q;
    assign released   = ~held_q & held_dly_q;
    assign long_press = held_q & tick & (hold_cnt_q == LONG_PRE);
    assign long_held  = long_held_q;

endmodule

// File: rtl/pb_debounce_multi.sv
// Multi-channel pushbutton conditioner: N_CH independent channels sharing
// clock, reset and the timing prescale tick.
module pb_debounce_multi
    import pb_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int LONG_CYCLES = DEF_LONG_CYCLES,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] PB,
    input  logic            tick,
    output logic [N_CH-1:0] held,
    output logic [N_CH-1:0] pressed,
    output logic [N_CH-1:0] released,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] long_held
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pb_debounce_ch #(
            .DB_CYCLES   (DB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .pb         (PB[g]),
            .tick       (tick),
            .held       (held[g]),
            .pressed    (pressed[g]),
            .released   (released[g]),
            .long_press (long_press[g]),
            .long_held  (long_held[g])
        );
    end

endmodule

// File: tb/tb_pb_debounce_multi.sv
// Bench for pb_debounce_multi: directed scenarios plus random bouncing input,
// all cycles compared against a behavioural model of the button rules.
module tb_pb_debounce_multi;

    localparam int N_CH        = 2;
    localparam int DB_CYCLES   = 4;
    localparam int LONG_CYCLES = 8;
    localparam bit ACTIVE_LOW  = 1'b1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            tick;
    logic [N_CH-1:0] pb;
    logic [N_CH-1:0] held, pressed, released, long_press, long_held;

    int n_checks = 0;
    int n_pass   = 0;
    int tick_mode  = 0;
    int tick_phase = 0;

    // Model state: raw samples in flight, accepted level, and plain counts of
    // disagreeing ticks and of ticks spent held (never saturated).
    logic [N_CH-1:0] m_s1, m_s2, m_held, m_prev;
    int m_dis   [N_CH];
    int m_htime [N_CH];
    int cnt_p   [N_CH];
    int cnt_r   [N_CH];
    int cnt_lp  [N_CH];

    always #5 clk = ~clk;

    pb_debounce_multi #(
        .N_CH        (N_CH),
        .DB_CYCLES   (DB_CYCLES),
        .LONG_CYCLES (LONG_CYCLES),
        .ACTIVE_LOW  (ACTIVE_LOW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PB         (pb),
        .tick       (tick),
        .held       (held),
        .pressed    (pressed),
        .released   (released),
        .long_press (long_press),
        .long_held  (long_held)
    );

    task automatic chk(input string name, input logic [N_CH-1:0] act, input logic [N_CH-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
    endtask

    task automatic model_edge();
        logic a;
        if (!rst_n) begin
            m_s1   = '1;
            m_s2   = '1;
            m_held = '0;
            m_prev = '0;
            for (int i = 0; i < N_CH; i++) begin
                m_dis[i]   = 0;
                m_htime[i] = 0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                a = m_s2[i] ^ ACTIVE_LOW;
                m_prev[i] = m_held[i];
                if (!m_prev[i]) m_htime[i] = 0;
                else if (tick) m_htime[i]++;
                if (a == m_prev[i]) m_dis[i] = 0;
                else if (tick) begin
                    m_dis[i]++;
                    if (m_dis[i] == DB_CYCLES) begin
                        m_held[i] = a;
                        m_dis[i]  = 0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = pb;
        end
    endtask

    task automatic compare_all();
        logic [N_CH-1:0] e_lp, e_lh;
        for (int i = 0; i < N_CH; i++) begin
            e_lh[i] = m_held[i] && (m_htime[i] >= LONG_CYCLES);
            e_lp[i] = m_held[i] && tick && (m_htime[i] == LONG_CYCLES - 1);
        end
        chk("held", held, m_held);
        chk("pressed", pressed, m_held & ~m_prev);
        chk("released", released, ~m_held & m_prev);
        chk("long_press", long_press, e_lp);
        chk("long_held", long_held, e_lh);
    endtask

    // One clock: model and compare just after the rising edge, then move the
    // tick on the falling edge where the caller also changes its inputs.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        for (int i = 0; i < N_CH; i++) begin
            cnt_p[i]  += int'(pressed[i]);
            cnt_r[i]  += int'(released[i]);
            cnt_lp[i] += int'(long_press[i]);
        end
        @(negedge clk);
        case (tick_mode)
            0: tick = 1'b1;
            1: tick = (tick_phase % 4 == 0);
            default: tick = ($urandom_range(0, 3) != 0);
        endcase
        tick_phase++;
    endtask

    // Steps until the named output of channel ch goes high; returns the number
    // of edges after the first one.
    task automatic wait_rise(input int sel, input int ch, input int limit, output int off);
        logic seen;
        off = 0;
        step();
        seen = 1'b0;
        while (off < limit) begin
            case (sel)
                0: seen = held[ch];
                1: seen = pressed[ch];
                2: seen = released[ch];
                default: seen = long_press[ch];
            endcase
            if (seen) break;
            step();
            off++;
        end
        if (!seen) $display("FAIL wait_rise sel=%0d ch=%0d timed out after %0d", sel, ch, limit);
    endtask

    initial begin
        int off, p0, r0, lp0, total;
        rst_n = 1'b0;
        pb    = '1;
        tick  = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            cnt_p[i] = 0; cnt_r[i] = 0; cnt_lp[i] = 0;
        end
        repeat (3) step();
        rst_n = 1'b1;

        // Idle after reset: nothing may happen.
        repeat (50) step();
        total = cnt_p[0] + cnt_p[1] + cnt_r[0] + cnt_r[1] + cnt_lp[0] + cnt_lp[1];
        chk_int("idle_events", total, 0);
        chk("idle_held", held, 2'b00);

        // Clean press on channel 0: held rises DB_CYCLES+1 edges after first sample.
        pb[0] = 1'b0;
        wait_rise(0, 0, 20, off);
        chk_int("press_latency", off, 5);
        chk("press_pulse", pressed, 2'b01);
        chk("press_ch1_held", held, 2'b01);

        // Keep holding: long_press on the 8th held cycle, long_held the next.
        lp0 = cnt_lp[0];
        off = 1;
        while (!long_press[0] && off < 30) begin
            step();
            off++;
        end
        chk_int("long_press_cycle", off, 8);
        step();
        chk("long_held_rise", long_held, 2'b01);
        chk("long_press_once", long_press, 2'b00);
        repeat (11) step();
        chk_int("long_press_count", cnt_lp[0] - lp0, 1);

        pb[0] = 1'b1;
        wait_rise(2, 0, 20, off);
        chk_int("release_latency", off, 5);
        chk("release_long_held", long_held, 2'b00);
        repeat (10) step();

        // Bounce: runs of 3 low samples never reach the 4 needed.
        p0 = cnt_p[0];
        for (int r = 0; r < 2; r++) begin
            pb[0] = 1'b0; repeat (3) step();
            pb[0] = 1'b1; step();
        end
        chk("bounce_no_held", held, 2'b00);
        pb[0] = 1'b0;
        repeat (15) step();
        chk_int("bounce_one_press", cnt_p[0] - p0, 1);

        // Reset while long-held: outputs clear at once, fresh press afterwards.
        repeat (10) step();
        chk("pre_reset_long_held", long_held, 2'b01);
        r0 = cnt_r[0];
        rst_n = 1'b0;
        #1;
        chk("reset_held", held, 2'b00);
        chk("reset_long_held", long_held, 2'b00);
        repeat (2) step();
        rst_n = 1'b1;
        wait_rise(1, 0, 20, off);
        chk_int("repress_latency", off, 5);
        chk_int("reset_no_release", cnt_r[0] - r0, 0);
        pb[0] = 1'b1;
        repeat (12) step();

        // Prescaled timing with a glitch between ticks on channel 1.
        tick_mode = 1;
        pb[1] = 1'b0;
        repeat (8) step();
        pb[1] = 1'b1;
        step();
        chk("tick_glitch_held", held, 2'b00);
        pb[1] = 1'b0;
        wait_rise(0, 1, 60, off);
        chk("tick_held_rise", held, 2'b10);
        pb[1] = 1'b1;
        repeat (40) step();

        // Random bouncing inputs with a random tick and the odd reset.
        tick_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N_CH; i++)
                if ($urandom_range(0, 9) == 0) pb[i] = ~pb[i];
            rst_n = ($urandom_range(0, 999) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
